// File: rtl/color_gain_filter.sv
// color_gain_filter: per-channel fixed-point pixel gain with saturation on a 2-stage valid/ready pipeline
//
// Scales each channel of a packed pixel by an unsigned gain (FRAC_BITS fractional
// bits) and clips the result to CH_W bits. Gains are written into a shadow set and
// copied to the active set on the accepted start-of-frame beat. That beat already
// uses the new gains.
//
// Build option: define CGF_ROUND_EN for round-half-up. Without it the block truncates.
//
// Ports:
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   in_valid_i/ready_o input stream handshake; in_ready_o = !out_valid_o || out_ready_i
//   in_sof_i           accepted beat starts a frame and applies the shadow gains
//   in_pix_i           packed pixel, ch0 in the LSBs
//   out_valid_o/ready_i output stream handshake
//   out_sof_o          frame-start flag aligned with out_pix_o
//   out_pix_o          packed scaled and saturated pixel
//   cfg_we_i           write cfg_gain_i into shadow[cfg_ch_i]; channels >= NUM_CH are ignored
//   cfg_pending_o      shadow written since the last frame start
module color_gain_filter #(
  parameter int NUM_CH    = 3,
  parameter int CH_W      = 8,
  parameter int GAIN_W    = 9,
  parameter int FRAC_BITS = 7,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_sof_i,
  input  logic [NUM_CH*CH_W-1:0]   in_pix_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_sof_o,
  output logic [NUM_CH*CH_W-1:0]   out_pix_o,
  input  logic                     cfg_we_i,
  input  logic [SEL_W-1:0]         cfg_ch_i,
  input  logic [GAIN_W-1:0]        cfg_gain_i,
  output logic                     cfg_pending_o
);
  localparam int PW = CH_W + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_BITS;
`ifdef CGF_ROUND_EN
  localparam logic [PW:0] HALF = (FRAC_BITS > 0) ? ((PW+1)'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
`else
  localparam logic [PW:0] HALF = '0;
`endif
  localparam logic [PW:0] MAXV = (PW+1)'({CH_W{1'b1}});
  logic [NUM_CH-1:0][GAIN_W-1:0] act_q, act_d, shd_q, shd_d;
  logic [NUM_CH-1:0][PW-1:0]     s1_p_q, s1_p_d;
  logic [NUM_CH-1:0][PW:0]       rnd;
  logic [NUM_CH-1:0][CH_W-1:0]   sat, s2_pix_q, s2_pix_d;
  logic pend_q, pend_d, s1_v_q, s1_v_d, s1_sof_q, s1_sof_d, s2_v_q, s2_v_d, s2_sof_q, s2_sof_d;
  logic adv, sof_acc, cfg_ok;
  always_comb begin
    adv      = !s2_v_q || out_ready_i;
    sof_acc  = in_valid_i && in_sof_i && adv;
    cfg_ok   = cfg_we_i && ({{(32-SEL_W){1'b0}}, cfg_ch_i} < 32'(NUM_CH));
    // the frame-start copy reads the shadow before this cycle's write lands
    act_d    = sof_acc ? shd_q : act_q;
    pend_d   = cfg_ok || (pend_q && !sof_acc);
    s1_v_d   = adv ? in_valid_i : s1_v_q;
    s1_sof_d = adv ? in_valid_i && in_sof_i : s1_sof_q;
    s2_v_d   = adv ? s1_v_q : s2_v_q;
    s2_sof_d = adv ? s1_sof_q : s2_sof_q;
    shd_d    = shd_q;
    s1_p_d   = s1_p_q;
    rnd      = '0;
    sat      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ok && cfg_ch_i == SEL_W'(c)) shd_d[c] = cfg_gain_i;
      s1_p_d[c] = adv ? PW'(in_pix_i[c*CH_W +: CH_W]) * PW'(act_d[c]) : s1_p_q[c];
      rnd[c]    = ({1'b0, s1_p_q[c]} + HALF) >> FRAC_BITS;
      sat[c]    = (rnd[c] > MAXV) ? {CH_W{1'b1}} : rnd[c][CH_W-1:0];
    end
    s2_pix_d = adv ? sat : s2_pix_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= {NUM_CH{UNITY}};
      shd_q    <= {NUM_CH{UNITY}};
      pend_q   <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_p_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_sof_q <= 1'b0;
      s2_pix_q <= '0;
    end else begin
      act_q    <= act_d;
      shd_q    <= shd_d;
      pend_q   <= pend_d;
      s1_v_q   <= s1_v_d;
      s1_sof_q <= s1_sof_d;
      s1_p_q   <= s1_p_d;
      s2_v_q   <= s2_v_d;
      s2_sof_q <= s2_sof_d;
      s2_pix_q <= s2_pix_d;
    end
  end
  assign in_ready_o    = adv;
  assign out_valid_o   = s2_v_q;
  assign out_sof_o     = s2_sof_q;
  assign out_pix_o     = s2_pix_q;
  assign cfg_pending_o = pend_q;
endmodule

// File: tb/tb_color_gain_filter.sv
// tb_color_gain_filter: directed self-checking bench for color_gain_filter
module tb_color_gain_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_sof = 1'b0;
  logic [23:0] in_pix = '0, out_pix;
  logic out_valid, out_ready = 1'b1, out_sof;
  logic cfg_we = 1'b0, cfg_pending;
  logic [1:0] cfg_ch = '0;
  logic [8:0] cfg_gain = '0;
  int checks = 0, errors = 0;
  int sent, rcvd;
  logic low_seen, acc, hold;
  color_gain_filter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sof_i(in_sof), .in_pix_i(in_pix),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sof_o(out_sof), .out_pix_o(out_pix),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_gain_i(cfg_gain), .cfg_pending_o(cfg_pending)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] px(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [23:0] pix, input logic sof);
    in_valid = 1'b1;
    in_pix   = pix;
    in_sof   = sof;
    cyc();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    cyc();
  endtask
  task automatic wr(input int ch, input int g);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_gain = 9'(g);
    cyc();
    cfg_we   = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sof", 32'(out_sof), 0);
    chk("rst_pix", 32'(out_pix), 0);
    chk("rst_pending", 32'(cfg_pending), 0);
    chk("rst_ready", 32'(in_ready), 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    in_valid = 1'b1;
    in_pix   = px(200, 100, 50);
    cyc();
    in_valid = 1'b0;
    chk("lat1_valid", 32'(out_valid), 0);
    cyc();
    chk("lat2_valid", 32'(out_valid), 1);
    chk("unity_pix", 32'(out_pix), 32'(px(200, 100, 50)));
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    wr(0, 'h100);
    chk("g2_pending", 32'(cfg_pending), 1);
    in_valid = 1'b1;
    in_pix   = px(200, 100, 50);
    in_sof   = 1'b1;
    cyc();
    chk("g2_pending_clr", 32'(cfg_pending), 0);
    in_pix = px(100, 100, 50);
    in_sof = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk("g2_sat_pix", 32'(out_pix), 32'(px(255, 100, 50)));
    chk("g2_sat_sof", 32'(out_sof), 1);
    cyc();
    chk("g2_dbl_pix", 32'(out_pix), 32'(px(200, 100, 50)));
    chk("g2_dbl_sof", 32'(out_sof), 0);
    cyc();
    wr(3, 0);
    chk("badch_pending", 32'(cfg_pending), 0);
    wr(0, 'h80);
    wr(2, 'h40);
    send(px(10, 20, 51), 1'b1);
`ifdef CGF_ROUND_EN
    chk("half_pix", 32'(out_pix), 32'(px(10, 20, 26)));
`else
    chk("half_pix", 32'(out_pix), 32'(px(10, 20, 25)));
`endif
    cyc();
    wr(2, 'h80);
    sent = 0;
    rcvd = 0;
    low_seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      in_valid  = sent < 6;
      in_pix    = px(10*sent + 1, 10*sent + 2, 10*sent + 3);
      in_sof    = sent == 0;
      out_ready = !(t >= 3 && t <= 7);
      #1;
      acc  = in_valid && in_ready;
      hold = out_valid && !out_ready;
      if (!in_ready) low_seen = 1'b1;
      if (out_valid && out_ready) begin
        chk("stall_pix", 32'(out_pix), 32'(px(10*rcvd + 1, 10*rcvd + 2, 10*rcvd + 3)));
        chk("stall_sof", 32'(out_sof), 32'(rcvd == 0));
        rcvd++;
      end
      cyc();
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_pix", 32'(out_pix), 32'(px(10*rcvd + 1, 10*rcvd + 2, 10*rcvd + 3)));
        chk("hold_sof", 32'(out_sof), 32'(rcvd == 0));
      end
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    chk("stall_sent", 32'(sent), 6);
    chk("stall_rcvd", 32'(rcvd), 6);
    chk("stall_ready_low", 32'(low_seen), 1);
    wr(1, 0);
    chk("mid_pending", 32'(cfg_pending), 1);
    send(px(5, 60, 7), 1'b0);
    chk("mid_old_gain", 32'(out_pix), 32'(px(5, 60, 7)));
    chk("mid_pending_hold", 32'(cfg_pending), 1);
    send(px(5, 60, 7), 1'b1);
    chk("sof_new_gain", 32'(out_pix), 32'(px(5, 0, 7)));
    chk("sof_new_sof", 32'(out_sof), 1);
    chk("sof_pending_clr", 32'(cfg_pending), 0);
    cfg_we   = 1'b1;
    cfg_ch   = 2'd1;
    cfg_gain = 9'h80;
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_pix   = px(5, 60, 7);
    cyc();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("coinc_pending", 32'(cfg_pending), 1);
    cyc();
    chk("coinc_old_shadow", 32'(out_pix), 32'(px(5, 0, 7)));
    send(px(5, 60, 7), 1'b1);
    chk("coinc_applied", 32'(out_pix), 32'(px(5, 60, 7)));
    chk("coinc_pending_clr", 32'(cfg_pending), 0);
    wr(0, 0);
    send(px(9, 9, 9), 1'b1);
    chk("pre_rst_gain", 32'(out_pix), 32'(px(0, 9, 9)));
    wr(2, 'h100);
    in_valid = 1'b1;
    in_pix   = px(9, 9, 9);
    cyc();
    cyc();
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_pix", 32'(out_pix), 32'(px(0, 9, 9)));
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_pix", 32'(out_pix), 0);
    chk("async_pending", 32'(cfg_pending), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_stale", 32'(out_valid), 0);
    end
    send(px(9, 9, 9), 1'b0);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_unity", 32'(out_pix), 32'(px(9, 9, 9)));
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
